// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and default sizing for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int DSIZE_DEF = 8;
  localparam int NREQ_DEF = 4;
  localparam int BURST_DEF = 4;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first requester with req set, searching upward from last_owner+1 mod NREQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] j;
  always_comb begin
    index = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(last_owner) + k) % NREQ);
      index = req[j] ? j : index;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: rotating-priority burst arbiter feeding one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                    wclk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    full,
  output logic                    wreq,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);
  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
  logic [BW-1:0] beat_q, beat_d;
  logic          pick_valid, take, release_now;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );
  assign take        = (state_q == GRANT) && req[owner_q] && !full;
  assign release_now = (state_q == GRANT) && (!req[owner_q] || (take && beat_q == BW'(BURST - 1)));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = take ? beat_q + 1'b1 : beat_q;
    if (state_q == IDLE && pick_valid && !full) begin
      state_d = GRANT;
      owner_d = pick_idx;
      beat_d  = '0;
    end
    if (release_now) begin
      state_d = IDLE;
      last_d  = owner_q;
      beat_d  = '0;
    end
  end
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end
  // Grant is combinational so a word is written in the same cycle it is offered.
  assign gnt   = take ? NREQ'(1) << owner_q : '0;
  assign wreq  = take;
  assign wdata = take ? req_data[owner_q*DSIZE +: DSIZE] : '0;
  assign busy  = state_q == GRANT;
  assign owner = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus randomized scoreboard for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [7:0] wdata;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  logic        wclk = 1'b0;
  logic        rst_n, full, wreq, busy;
  logic [3:0]  req, gnt;
  logic [31:0] req_data;
  logic [7:0]  wdata;
  logic [1:0]  owner;
  logic [5:0]  seq [4] = '{6'd1, 6'd1, 6'd1, 6'd1};
  logic [5:0]  nexp [4];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl [$];

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .full     (full),
    .wreq     (wreq),
    .wdata    (wdata),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 wclk = ~wclk;

  // Requester i offers {i, seq[i]}; its sequence advances each time its word is taken.
  always_comb
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), seq[i]};

  always @(posedge wclk)
    for (int i = 0; i < 4; i++) if (gnt[i]) seq[i] <= seq[i] + 6'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void v(input logic r, input logic [3:0] rq, input logic f, input logic [3:0] g,
                            input logic [7:0] d, input logic b, input logic [1:0] o);
    tbl.push_back('{r, rq, f, g, d, b, o});
  endfunction

  initial begin
    logic [1:0] r;
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    // reset holds everything quiet even with requests pending
    v(0, 4'hF, 0, 0, 0, 0, 0);
    v(0, 4'hF, 0, 0, 0, 0, 0);
    // single requester, burst of 4 then a bubble then 2 more words
    v(1, 4'h1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) v(1, 4'h1, 0, 4'h1, 8'(1 + k), 1, 0);
    v(1, 4'h1, 0, 0, 0, 0, 0);
    v(1, 4'h1, 0, 4'h1, 8'h05, 1, 0);
    v(1, 4'h1, 0, 4'h1, 8'h06, 1, 0);
    v(1, 4'h0, 0, 0, 0, 1, 0);
    v(1, 4'h0, 0, 0, 0, 0, 0);
    // all requesting: rotation 1,2,3,0 with one bubble between bursts
    v(1, 4'hF, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) v(1, 4'hF, 0, 4'h2, 8'(8'h41 + k), 1, 1);
    v(1, 4'hF, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) v(1, 4'hF, 0, 4'h4, 8'(8'h81 + k), 1, 2);
    v(1, 4'hF, 0, 0, 0, 0, 2);
    for (int k = 0; k < 4; k++) v(1, 4'hF, 0, 4'h8, 8'(8'hC1 + k), 1, 3);
    v(1, 4'hF, 0, 0, 0, 0, 3);
    for (int k = 0; k < 4; k++) v(1, 4'hF, 0, 4'h1, 8'(8'h07 + k), 1, 0);
    v(1, 4'h0, 0, 0, 0, 0, 0);
    // full stall for 5 cycles mid-burst of owner 1
    v(1, 4'h2, 0, 0, 0, 0, 0);
    v(1, 4'h2, 0, 4'h2, 8'h45, 1, 1);
    v(1, 4'h2, 0, 4'h2, 8'h46, 1, 1);
    for (int k = 0; k < 5; k++) v(1, 4'h2, 1, 0, 0, 1, 1);
    v(1, 4'h2, 0, 4'h2, 8'h47, 1, 1);
    v(1, 4'h2, 0, 4'h2, 8'h48, 1, 1);
    v(1, 4'h0, 0, 0, 0, 0, 1);
    // owner 2 drops after one word, owner 3 next; full blocks a grant from IDLE
    v(1, 4'h4, 0, 0, 0, 0, 1);
    v(1, 4'h4, 0, 4'h4, 8'h85, 1, 2);
    v(1, 4'h9, 0, 0, 0, 1, 2);
    v(1, 4'h9, 0, 0, 0, 0, 2);
    v(1, 4'h9, 0, 4'h8, 8'hC5, 1, 3);
    v(1, 4'h0, 0, 0, 0, 1, 3);
    v(1, 4'h0, 0, 0, 0, 0, 3);
    v(1, 4'hF, 1, 0, 0, 0, 3);
    v(1, 4'hF, 1, 0, 0, 0, 3);
    v(1, 4'h0, 0, 0, 0, 0, 3);
    // asynchronous reset mid-burst of owner 2, then requester 0 wins
    v(1, 4'h4, 0, 0, 0, 0, 3);
    v(1, 4'h4, 0, 4'h4, 8'h86, 1, 2);
    v(1, 4'h4, 0, 4'h4, 8'h87, 1, 2);
    v(0, 4'h4, 0, 0, 0, 0, 0);
    v(1, 4'h5, 0, 0, 0, 0, 0);
    v(1, 4'h5, 0, 4'h1, 8'h0B, 1, 0);
    v(1, 4'h0, 0, 0, 0, 1, 0);
    v(1, 4'h0, 0, 0, 0, 0, 0);
    #1;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      req   = tbl[i].req;
      full  = tbl[i].full;
      #2;
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d wreq", i), 32'(wreq), 32'(|tbl[i].gnt));
      chk($sformatf("v%0d wdata", i), 32'(wdata), 32'(tbl[i].wdata));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].owner));
      @(posedge wclk);
      #1;
    end
    // random traffic: no overflow, one-hot grants, each requester's words in order
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) nexp[i] = seq[i];
    for (int c = 0; c < 3000; c++) begin
      req  = 4'($urandom_range(0, 15));
      full = ($urandom_range(0, 3) == 0);
      #2;
      chk("rnd overflow", 32'(wreq & full), 32'd0);
      chk("rnd onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rnd wreq", 32'(wreq), 32'(|gnt));
      if (wreq) begin
        r = wdata[7:6];
        chk("rnd source", 32'(gnt), 32'(4'b0001 << r));
        chk("rnd order", 32'(wdata[5:0]), 32'(nexp[r]));
        nexp[r] = nexp[r] + 6'd1;
      end
      @(posedge wclk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
